// File: rtl/rv_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, with a start/busy/done handshake and *W word variants.
module rv_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic            word,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(31);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    state_t state, state_nxt;

    logic [2:0]        op_r;
    logic              word_r;
    logic              neg_r;
    logic              rneg_r;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   divisor;

    logic              is_div, word_eff, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_val, special_res;
    logic              div_zero, div_ovf, special, accept, last;

    // Operand capture decode: extension, magnitudes and special-case divides.
    always_comb begin
        is_div   = func3[2];
        word_eff = (XLEN == 64) && word && (is_div || func3 == 3'b000);
        a_signed = is_div ? !func3[0] : (func3[1:0] != 2'b11);
        b_signed = is_div ? !func3[0] : !func3[1];
        ext_a    = op_a;
        ext_b    = op_b;
        if (word_eff) begin
            ext_a = a_signed ? sext32(op_a[31:0]) : zext32(op_a[31:0]);
            ext_b = b_signed ? sext32(op_b[31:0]) : zext32(op_b[31:0]);
        end
        a_neg    = a_signed && ext_a[XLEN-1];
        b_neg    = b_signed && ext_b[XLEN-1];
        mag_a    = a_neg ? -ext_a : ext_a;
        mag_b    = b_neg ? -ext_b : ext_b;
        min_val  = word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (ext_b == '0);
        div_ovf  = is_div && !func3[0] && (ext_a == min_val) && (ext_b == '1);
        special  = div_zero || div_ovf;
        if (func3[1]) special_res = div_zero ? ext_a : '0;
        else          special_res = div_zero ? '1 : ext_a;
        if (word_eff) special_res = sext32(special_res[31:0]);
    end

    assign accept = start && !flush && (state != CALC);
    assign last   = (cnt == (word_r ? LAST_WORD : LAST_FULL));
    assign busy   = (state == CALC);
    assign done   = (state == DONE);

    logic [2*XLEN-1:0] prod_sum, prod_fin;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, calc_raw, calc_res;

    always_comb begin
        prod_sum = prod + (mplier[0] ? mcand : '0);
        prod_fin = neg_r ? -prod_sum : prod_sum;
        rem_sh   = {rem, quo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, divisor};
        q_bit    = !rem_diff[XLEN];
        rem_nxt  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nxt  = {quo[XLEN-2:0], q_bit};
        case (op_r)
            3'b000:                 calc_raw = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_raw = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_raw = neg_r ? -quo_nxt : quo_nxt;
            default:                calc_raw = rneg_r ? -rem_nxt : rem_nxt;
        endcase
        calc_res = word_r ? sext32(calc_raw[31:0]) : calc_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = special ? DONE : CALC;
                CALC:    if (last)  state_nxt = DONE;
                DONE:    state_nxt = start ? (special ? DONE : CALC) : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= '0;
            word_r  <= 1'b0;
            neg_r   <= 1'b0;
            rneg_r  <= 1'b0;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            result  <= '0;
        end else if (accept) begin
            op_r    <= func3;
            word_r  <= word_eff;
            neg_r   <= a_neg ^ b_neg;
            rneg_r  <= a_neg;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, mag_a};
            mplier  <= mag_b;
            rem     <= '0;
            // Word dividends are pre-aligned so the shared MSB-first loop sees bit 31 first.
            quo     <= word_eff ? (mag_a << 32) : mag_a;
            divisor <= mag_b;
            if (special) result <= special_res;
        end else if (state == CALC && !flush) begin
            prod    <= prod_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            rem     <= rem_nxt;
            quo     <= quo_nxt;
            cnt     <= cnt + CW'(1);
            if (last) result <= calc_res;
        end
    end

endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Multi-cycle RV64M multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage. It uses the same func3 decode style as the ALU control path, generalised to a parametrised XLEN with RV64 word (*W) variants. Operations run as an iterative shift-add multiply or a restoring divide, one result bit per cycle, under a start/busy/done handshake. The pipeline stalls on `busy`.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64 supported; `word` is ignored when XLEN=32

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when idle or in the DONE cycle
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- word  in  1  RV64 *W op; honoured for func3 000 and 1xx, ignored for 001–011
- flush  in  1  synchronous abort
- op_a  in  XLEN  rs1 / dividend
- op_b  in  XLEN  rs2 / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; `result` is valid in this cycle
- result  out  XLEN  registered result, held until the next `done`

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: iterates; `busy`=1.
  - DONE: `done`=1, `busy`=0; also accepts `start`.
- Transitions:
  - IDLE or DONE with `start` goes to CALC, or to DONE directly for special cases.
  - DONE without `start` goes to IDLE.
  - CALC goes to DONE after W iterations.
- Effective width W is 32 when (`word` && XLEN=64 && op valid for word), otherwise XLEN.
- Operand capture:
  - For word ops, the low 32 bits are taken and sign-extended (signed ops) or zero-extended (unsigned ops).
  - Magnitudes of signed operands are stored.
  - Result-sign flags are stored.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Multiply:
  - 2W-bit product of the magnitudes, accumulated one bit per cycle (shift-add, W iterations).
  - In the final iteration the product is negated if the sign flag is set.
  - MUL returns the low W bits. MULH, MULHSU and MULHU return the high W bits.
- Divide:
  - Restoring, W iterations on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend sign.
- Word results: the 32-bit result is sign-extended from bit 31 to XLEN. This applies to DIVUW and REMUW as well.
- Special cases are resolved at capture with no iterations:
  - Divide by zero: quotient = all ones; remainder = dividend (after word extension).
  - Signed overflow (dividend = −2^(W−1), divisor = −1): quotient = dividend; remainder = 0.
- Priority and boundary rules:
  - `flush` wins over everything. At the next edge: state = IDLE, no `done`, `result` unchanged.
  - `flush` and `start` in the same cycle: the request is dropped.
  - `start` while in CALC is ignored; no queuing.
- Reset (async assert, any state, including mid-operation): state = IDLE, `busy`=0, `done`=0, `result`=0, iteration counter = 0, internal accumulators = 0.

## Timing
- `start` high in cycle 0 is accepted at the end of cycle 0.
- Normal ops:
  - `busy`=1 in cycles 1..W.
  - `done`=1 and `result` valid in cycle W+1.
  - Latency is 65 for a 64-bit op and 33 for a word op or XLEN=32.
- Special-case divides: `done` in cycle 1; `busy` never asserts.
- Back-to-back: `start` in the DONE cycle is accepted; the next `done` follows at the same latency.
- `done` is exactly one cycle wide. `busy` and `done` are never high together.
- The iteration counter is $clog2(XLEN)+1 bits wide and does not wrap.

## Test plan
- MULHU: op_a = op_b = 0xFFFF_FFFF_FFFF_FFFF, start in cycle 0 -> `done` in cycle 65, result 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands -> 0x0; MULHSU with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV: −7 / 2 -> result 0xFFFF_FFFF_FFFF_FFFD at cycle 65. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Divide by zero: DIVU 7 / 0 -> 0xFFFF_FFFF_FFFF_FFFF in cycle 1 with `busy` never high. REM 7 / 0 -> 7 in cycle 1.
- Word ops:
  - DIVW with op_a = 0x0000_0000_8000_0000 and op_b = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000 in cycle 1.
  - MULW with op_a = 0x1_0000_0003 and op_b = 0x7FFF_FFFF -> 0x0000_0000_7FFF_FFFD in cycle 33.
- Control:
  - Flush in cycle 10 -> IDLE in cycle 11, no `done`, prior `result` retained.
  - `start` during CALC -> ignored.
  - `start` in the DONE cycle -> second `done` exactly W+1 cycles later.
- Reset: `rst_n` low in cycle 20 of a DIV -> immediately `busy`=0, `done`=0, `result`=0. After release, a new MUL 3 × 5 -> 15 at cycle 65.
